// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner and the display select logic.
//   kp_state_e : scanner FSM states (IDLE / PRESSED / MULTI)
//   ACTIVE_LOW : column selects are driven low to activate a column
//   COL_IDLE   : column bus value with no column selected
//   key_code_f : key code for a (row, column) position = {row, col}
//   col_drive  : column bus value selecting column c
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      MULTI   = 2'd2
   } kp_state_e;

   localparam bit         ACTIVE_LOW = 1'b1;
   localparam logic [3:0] COL_IDLE   = ACTIVE_LOW ? 4'b1111 : 4'b0000;

   function automatic logic [3:0] key_code_f(input logic [1:0] r, input logic [1:0] c);
      return {r, c};
   endfunction

   function automatic logic [3:0] col_drive(input logic [1:0] c);
      logic [3:0] onehot;
      onehot = 4'b0001 << c;
      return ACTIVE_LOW ? ~onehot : onehot;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer for the keypad matrix.
//   clk, rst_n : clock, synchronous active-low reset
//   frame_end  : high on the last cycle of a scan frame; snap is complete then
//   snap       : full-matrix snapshot of this frame, bit r*4+c = key pressed
//   accept     : high in the frame_end cycle where the snapshot becomes stable
//   snap_out   : the snapshot being accepted (valid with accept)
module keypad_debounce #(
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_end,
   input  logic [15:0] snap,
   output logic        accept,
   output logic [15:0] snap_out
);

   localparam int unsigned SW = $clog2(DEBOUNCE + 1);

   logic [SW-1:0] stable_cnt;
   logic [SW-1:0] cnt_d;
   logic [15:0]   prev_snap;
   logic          same;

   always_comb begin
      same = (snap == prev_snap);
      if (same)
         cnt_d = (stable_cnt == SW'(DEBOUNCE)) ? stable_cnt : stable_cnt + SW'(1);
      else
         cnt_d = SW'(1);
      // Accept only on the frame where the count arrives at DEBOUNCE; a
      // saturated, unchanged snapshot is not offered again.
      accept   = frame_end && (cnt_d == SW'(DEBOUNCE)) &&
                 !(same && (stable_cnt == SW'(DEBOUNCE)));
      snap_out = snap;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stable_cnt <= '0;
         prev_snap  <= '0;
      end else if (frame_end) begin
         stable_cnt <= cnt_d;
         prev_snap  <= snap;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner with frame debouncing.
//   clk, rst_n : clock, synchronous active-low reset
//   row        : matrix rows, active-low, asynchronous to clk
//   col        : column drive, active-low, at most one bit low
//   key_code   : code of the last accepted single key (row*4 + col)
//   key_valid  : one-cycle pulse per newly accepted single key
//   key_down   : accepted snapshot holds exactly one key
//   multi_key  : accepted snapshot holds more than one key
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 1024,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down,
   output logic       multi_key
);

   localparam int unsigned DW = $clog2(SCAN_DIV);

   logic [DW-1:0] dwell;
   logic [1:0]    col_idx;
   logic          scan_en;
   logic [3:0]    row_meta;
   logic [3:0]    row_sync;
   logic [15:0]   work_snap;
   logic [15:0]   frame_snap;
   logic [15:0]   acc_snap;
   logic          last_dwell;
   logic          frame_end;
   logic          accept;

   kp_state_e     state, state_d;
   logic [3:0]    code_d;
   logic          valid_d;
   logic [4:0]    n_keys;
   logic [3:0]    hit_code;

   // scan_en holds the columns idle for the reset cycle(s) so that the first
   // cycle after release starts a full dwell on column 0.
   assign last_dwell = scan_en && (dwell == DW'(SCAN_DIV - 1));
   assign frame_end  = last_dwell && (col_idx == 2'd3);
   assign col        = scan_en ? col_drive(col_idx) : COL_IDLE;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_meta  <= '1;
         row_sync  <= '1;
         scan_en   <= 1'b0;
         dwell     <= '0;
         col_idx   <= '0;
         work_snap <= '0;
      end else begin
         row_meta <= row;
         row_sync <= row_meta;
         scan_en  <= 1'b1;
         if (scan_en) begin
            if (last_dwell) begin
               dwell   <= '0;
               col_idx <= col_idx + 2'd1;
               for (int unsigned r = 0; r < 4; r++)
                  work_snap[{2'(r), col_idx}] <= ~row_sync[r];
            end else begin
               dwell <= dwell + DW'(1);
            end
         end
      end
   end

   // Column 3 is still being sampled at frame end, so merge it in directly.
   always_comb begin
      frame_snap = work_snap;
      for (int unsigned r = 0; r < 4; r++)
         frame_snap[{2'(r), 2'd3}] = ~row_sync[r];
   end

   keypad_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_end (frame_end),
      .snap      (frame_snap),
      .accept    (accept),
      .snap_out  (acc_snap)
   );

   always_comb begin
      state_d  = state;
      code_d   = key_code;
      valid_d  = 1'b0;
      n_keys   = '0;
      hit_code = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (acc_snap[i]) begin
            n_keys   = n_keys + 5'd1;
            hit_code = key_code_f(2'(i >> 2), 2'(i));
         end
      end
      if (accept) begin
         if (n_keys == 5'd0) begin
            state_d = IDLE;
         end else if (n_keys == 5'd1) begin
            if (state != PRESSED || hit_code != key_code) begin
               state_d = PRESSED;
               code_d  = hit_code;
               valid_d = 1'b1;
            end
         end else begin
            state_d = MULTI;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         key_code  <= '0;
         key_valid <= 1'b0;
      end else begin
         state     <= state_d;
         key_code  <= code_d;
         key_valid <= valid_d;
      end
   end

   assign key_down  = (state == PRESSED);
   assign multi_key = (state == MULTI);

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=2).
// A key matrix model drives rows from col; a frame-level reference model
// predicts outputs and pushes expected pulses into a scoreboard queue that a
// separate monitor drains whenever key_valid is seen.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DB = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;
   logic       multi_key;

   logic [15:0] pressed;

   keypad_scanner #(
      .SCAN_DIV (SD),
      .DEBOUNCE (DB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down),
      .multi_key (multi_key)
   );

   always #5 clk = ~clk;

   // Key matrix: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && col[c] === 1'b0) row[r] = 1'b0;
   end

   typedef struct { int code; int due; } exp_t;
   exp_t exp_q[$];

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   bit checking   = 0;

   // Reference model state (frame granularity)
   int          phase;
   logic [15:0] cur_f, prev_f;
   int          cnt;
   int          mstate;      // 0 none, 1 one key, 2 several keys
   int          mcode;
   logic [3:0]  exp_col;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         checking = 1;
         phase  = -1;
         cur_f  = '0;
         prev_f = '0;
         cnt    = 0;
         mstate = 0;
         mcode  = 0;
      end else begin
         phase = (phase < 0) ? 0 : phase + 1;
         // Rows are seen two cycles late, so a column reads the keys as they
         // stood in its second dwell cycle.
         if (phase % SD == 2) begin
            int c;
            c = (phase / SD) % 4;
            for (int r = 0; r < 4; r++) cur_f[r*4+c] = pressed[r*4+c];
         end
         if (phase > 0 && phase % (4*SD) == 0) begin
            bit same;
            int old;
            int n;
            int code;
            same = (cur_f == prev_f);
            old  = cnt;
            cnt  = same ? ((cnt < DB) ? cnt + 1 : DB) : 1;
            prev_f = cur_f;
            if (cnt == DB && !(same && old == DB)) begin
               n = $countones(cur_f);
               code = 0;
               for (int i = 0; i < 16; i++) if (cur_f[i]) code = i;
               if (n == 0) mstate = 0;
               else if (n > 1) mstate = 2;
               else if (mstate != 1 || code != mcode) begin
                  mstate = 1;
                  mcode  = code;
                  exp_q.push_back('{code: code, due: cyc});
               end
            end
         end
      end
      exp_col = (phase < 0) ? 4'hF : ~(4'b0001 << ((phase / SD) % 4));
   end

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (checking) begin
         chk("col", col, exp_col);
         chk("key_code", key_code, mcode);
         chk("key_down", key_down, mstate == 1);
         chk("multi_key", multi_key, mstate == 2);
         if (key_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_pulse cyc=%0d actual code=%0d required no pulse", cyc, key_code);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("pulse_code", key_code, e.code);
               chk("pulse_cycle", cyc, e.due);
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_pulse cyc=%0d actual none required code=%0d", cyc, exp_q[0].code);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic hold(input logic [15:0] p, input int n);
      pressed = p;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d actual running required finished", cyc);
      $fatal(1);
   end

   initial begin
      logic [15:0] p;
      rst_n   = 1'b0;
      pressed = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      hold(16'h0000, 40);                 // idle scan
      hold(16'h0040, 60);                 // r1c2 -> code 6
      hold(16'h0000, 48);                 // release
      repeat (6) begin                    // bounce r1c2
         hold(16'h0040, $urandom_range(5, 11));
         hold(16'h0000, $urandom_range(5, 11));
      end
      hold(16'h0040, 60);
      hold(16'h0000, 48);
      hold(16'h8000, 60);                 // r3c3 -> code 15
      hold(16'h0002, 60);                 // direct roll -> code 1
      hold(16'h0001, 60);                 // r0c0 -> code 0
      hold(16'h0021, 60);                 // r0c0 + r1c1 -> multi
      hold(16'h0001, 60);                 // back to r0c0, same code re-pulses
      hold(16'h0000, 48);
      hold(16'h0200, 60);                 // r2c1 -> code 9
      hold(16'h0200, $urandom_range(1, 15));
      rst_n = 1'b0;                       // reset while held
      hold(16'h0200, 2);
      rst_n = 1'b1;
      hold(16'h0200, 60);                 // re-pulse code 9
      hold(16'h0000, 48);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0:       p = '0;
            1, 2:    p = 16'd1 << $urandom_range(0, 15);
            default: p = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
         endcase
         hold(p, $urandom_range(8, 70));
      end
      hold(16'h0000, 60);
      repeat (4) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL pending_pulses actual=%0d required=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
